// File: rtl/detector_de_flags_if.sv
`default_nettype none
// ============================================================================
// Module      : detector_de_flags_if
// Description : ALU-result / status-flag bundle between the ALU datapath and
//               the flag detector.
// Revision    : 1.0 - initial release
// ============================================================================
interface detector_de_flags_if #(
    parameter int WIDTH = 32
);
    logic             Enable_overflow;
    logic [WIDTH-1:0] Data_in;
    logic             Signal_A;
    logic             Signal_B;
    logic             Signal_Result;
    logic             Selection_Sum_Sub;
    logic             Overflow;
    logic             Zero;

    // ALU side: drives the result and operand signs, observes the flags.
    modport master (
        output Enable_overflow,
        output Data_in,
        output Signal_A,
        output Signal_B,
        output Signal_Result,
        output Selection_Sum_Sub,
        input  Overflow,
        input  Zero
    );

    // Flag detector side.
    modport slave (
        input  Enable_overflow,
        input  Data_in,
        input  Signal_A,
        input  Signal_B,
        input  Signal_Result,
        input  Selection_Sum_Sub,
        output Overflow,
        output Zero
    );
endinterface : detector_de_flags_if
`default_nettype wire

// File: rtl/detector_de_flags.sv
`default_nettype none
// ============================================================================
// Module      : detector_de_flags
// Description : Registered signed-overflow and zero flags for the 32-bit ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module detector_de_flags #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    detector_de_flags_if.slave    bus
);

    logic w_same_sign_ab;
    logic w_result_flipped;
    logic w_ovf_add;
    logic w_ovf_sub;
    logic w_ovf_next;
    logic w_zero_next;

    logic r_overflow;
    logic r_zero;

    // Overflow only when the result sign departs from A while the effective
    // operand signs agree (subtraction negates B, hence the inverted test).
    assign w_same_sign_ab   = (bus.Signal_A == bus.Signal_B);
    assign w_result_flipped = (bus.Signal_Result != bus.Signal_A);
    assign w_ovf_add        =  w_same_sign_ab && w_result_flipped;
    assign w_ovf_sub        = !w_same_sign_ab && w_result_flipped;

    assign w_ovf_next  = bus.Enable_overflow &&
                         (bus.Selection_Sum_Sub ? w_ovf_sub : w_ovf_add);
    assign w_zero_next = (bus.Data_in == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_overflow <= w_ovf_next;
            r_zero     <= w_zero_next;
        end
    end

    assign bus.Overflow = r_overflow;
    assign bus.Zero     = r_zero;

endmodule : detector_de_flags
`default_nettype wire

// File: tb/tb_detector_de_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_detector_de_flags
// Description : Scoreboard bench for detector_de_flags with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_detector_de_flags;

    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;

    detector_de_flags_if #(.WIDTH(WIDTH)) bus ();

    detector_de_flags #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  ovf;
        logic  zero;
        string name;
    } exp_t;

    exp_t q_exp[$];
    int   n_vec;
    int   n_err;
    bit   stim_done;

    // Compare helper shared by reset checks and the monitor.
    task automatic check(input string name, input logic act_o, input logic act_z,
                         input logic exp_o, input logic exp_z);
        n_vec++;
        if (act_o !== exp_o || act_z !== exp_z) begin
            n_err++;
            $display("FAIL %s: Overflow/Zero got %b/%b expected %b/%b",
                     name, act_o, act_z, exp_o, exp_z);
        end
    endtask

    // Drive one vector on the falling edge and record its expected flags.
    task automatic apply(input string name, input logic en, input logic sel,
                         input logic sa, input logic sb, input logic sr,
                         input logic [WIDTH-1:0] data,
                         input logic exp_o, input logic exp_z);
        exp_t e;
        @(negedge clk);
        bus.Enable_overflow   = en;
        bus.Selection_Sum_Sub = sel;
        bus.Signal_A          = sa;
        bus.Signal_B          = sb;
        bus.Signal_Result     = sr;
        bus.Data_in           = data;
        e.ovf  = exp_o;
        e.zero = exp_z;
        e.name = name;
        q_exp.push_back(e);
    endtask

    // Monitor: each rising edge out of reset presents the flags for the
    // vector driven before it.
    initial begin : p_monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check(e.name, bus.Overflow, bus.Zero, e.ovf, e.zero);
            end
        end
    end

    initial begin : p_stim
        n_vec     = 0;
        n_err     = 0;
        stim_done = 1'b0;

        // Reset held with zero data and an add-overflow pattern present.
        rst_n                 = 1'b0;
        bus.Enable_overflow   = 1'b1;
        bus.Selection_Sum_Sub = 1'b0;
        bus.Signal_A          = 1'b0;
        bus.Signal_B          = 1'b0;
        bus.Signal_Result     = 1'b1;
        bus.Data_in           = '0;
        #2;
        check("reset_async", bus.Overflow, bus.Zero, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", bus.Overflow, bus.Zero, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q_exp.push_back('{ovf: 1'b1, zero: 1'b1, name: "reset_release"});

        apply("add_ovf",        1, 0, 0, 0, 1, 32'h8000_0000, 1, 0);
        apply("sub_ovf",        1, 1, 1, 0, 0, 32'h7FFF_FFFF, 1, 0);
        apply("sub_ovf_dis",    0, 1, 1, 0, 0, 32'h7FFF_FFFF, 0, 0);
        apply("sub_zero",       1, 1, 0, 0, 0, 32'h0000_0000, 0, 1);
        apply("add_both",       1, 0, 1, 1, 0, 32'h0000_0000, 1, 1);
        apply("add_neg_ok",     1, 0, 1, 1, 1, 32'h8000_0000, 0, 0);
        apply("sub_pos_neg",    1, 1, 0, 1, 1, 32'h8000_0001, 1, 0);
        apply("sub_pos_neg_ok", 1, 1, 0, 1, 0, 32'h0000_0007, 0, 0);
        apply("add_mixed_ok",   1, 0, 0, 1, 1, 32'hFFFF_FFFF, 0, 0);
        apply("zero_lsb",       1, 0, 0, 0, 0, 32'h0000_0001, 0, 0);
        apply("zero_msb",       0, 0, 0, 0, 1, 32'h8000_0000, 0, 0);
        apply("inc_ovf",        1, 0, 0, 0, 1, 32'h8000_0000, 1, 0);
        apply("dis_zero",       0, 0, 1, 1, 0, 32'h0000_0000, 0, 1);

        // Back-to-back alternation of zero and overflow vectors.
        apply("b2b_zero0",      1, 1, 0, 0, 0, 32'h0000_0000, 0, 1);
        apply("b2b_ovf0",       1, 0, 0, 0, 1, 32'h8000_0000, 1, 0);
        apply("b2b_zero1",      1, 1, 0, 0, 0, 32'h0000_0000, 0, 1);
        apply("b2b_ovf1",       1, 1, 1, 0, 0, 32'h7FFF_FFFF, 1, 0);
        apply("b2b_both",       1, 0, 1, 1, 0, 32'h0000_0000, 1, 1);
        apply("b2b_none",       0, 1, 1, 0, 0, 32'h1234_5678, 0, 0);
        apply("pre_reset",      1, 0, 1, 1, 0, 32'h0000_0000, 1, 1);

        // Mid-stream reset clears both flags without waiting for an edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_mid", bus.Overflow, bus.Zero, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_mid_hold", bus.Overflow, bus.Zero, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.Enable_overflow   = 1'b1;
        bus.Selection_Sum_Sub = 1'b1;
        bus.Signal_A          = 1'b1;
        bus.Signal_B          = 1'b0;
        bus.Signal_Result     = 1'b0;
        bus.Data_in           = 32'h7FFF_FFFF;
        q_exp.push_back('{ovf: 1'b1, zero: 1'b0, name: "post_reset"});
        apply("post_reset_zero", 1, 1, 0, 0, 0, 32'h0000_0000, 0, 1);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && q_exp.size() > 0; i++) @(posedge clk);
        #2;
        if (q_exp.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected responses left, required 0", q_exp.size());
        end
        stim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : p_watchdog
        #20000;
        if (!stim_done) begin
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
        end
    end

endmodule : tb_detector_de_flags
`default_nettype wire
